// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the SPI ADC reader.
package spi_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE,
        ST_QUIET
    } state_t;

    // SCLK rests high between frames (CPOL=1).
    localparam logic SCLK_IDLE = 1'b1;

    // Total SCLK periods in one read frame.
    function automatic int nb_frame(input int nb_lead, input int nb_data);
        return nb_lead + nb_data;
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator: one tick every CLK_DIV enabled cycles.
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV + 1);
    localparam logic [W-1:0] LOAD = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    // Down-counter reloads on each tick so phases stay exactly CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= LOAD;
        end else if (en) begin
            if (cnt == '0) cnt <= LOAD;
            else           cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_adc_reader.sv
// SPI (CPOL=1/CPHA=1, MSB first) ADC frame reader with CS framing and quiet time.
// Optional feature: define ADC_TEST_PATTERN_EN to add i_pattern_en and a frame counter
// that can replace the SPI sample.
module spi_adc_reader
    import spi_adc_pkg::*;
#(
    parameter int NB_DATA   = 12,
    parameter int NB_LEAD   = 4,
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_trigger,
    input  logic               i_miso,
`ifdef ADC_TEST_PATTERN_EN
    input  logic               i_pattern_en,
`endif
    output logic               o_cs_n,
    output logic               o_sclk,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_sample
);

    localparam int NB_FRAME = nb_frame(NB_LEAD, NB_DATA);
    localparam int BW       = $clog2(NB_FRAME + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NB_FRAME - 1);
    localparam int QW       = (QUIET_CYC > 0) ? $clog2(QUIET_CYC + 1) : 1;
    localparam int QLOAD    = (QUIET_CYC > 0) ? QUIET_CYC - 1 : 0;
    localparam logic [QW-1:0] QUIET_LOAD = QW'(QLOAD);

    state_t             state, state_nx;
    logic               in_frame;
    logic               tick;
    logic               sclk_q;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shift_reg;
    logic [QW-1:0]      quiet_cnt;

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (in_frame),
        .clr  (!in_frame),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; CS is asserted for the three framed states only.
    always_comb begin
        state_nx = state;
        in_frame = 1'b0;
        unique case (state)
            ST_IDLE:     if (i_trigger) state_nx = ST_CS_SETUP;
            ST_CS_SETUP: begin
                in_frame = 1'b1;
                if (tick) state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                in_frame = 1'b1;
                if (tick && sclk_q && bit_cnt == LAST_BIT) state_nx = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                in_frame = 1'b1;
                if (tick) state_nx = ST_DONE;
            end
            ST_DONE:     state_nx = (QUIET_CYC == 0) ? ST_IDLE : ST_QUIET;
            ST_QUIET:    if (quiet_cnt == '0) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

`ifdef ADC_TEST_PATTERN_EN
    logic [NB_DATA-1:0] pat_cnt;

    // Frame counter advances on every completed frame, whether or not it is shown.
    always_ff @(posedge clk) begin
        if (rst)                               pat_cnt <= '0;
        else if (state == ST_CS_HOLD && tick)  pat_cnt <= pat_cnt + 1'b1;
    end
`endif

    // SCLK phase, shift register, bit counter, sample and quiet countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q    <= SCLK_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            quiet_cnt <= '0;
            o_sample  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sclk_q  <= SCLK_IDLE;
                    bit_cnt <= '0;
                end
                ST_CS_SETUP: if (tick) sclk_q <= 1'b0;
                ST_SHIFT: if (tick) begin
                    if (!sclk_q) begin
                        // Rising SCLK: capture MISO; lead bits fall off the top.
                        sclk_q    <= 1'b1;
                        shift_reg <= {shift_reg[NB_DATA-2:0], i_miso};
                    end else if (bit_cnt != LAST_BIT) begin
                        sclk_q  <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_CS_HOLD: if (tick) begin
`ifdef ADC_TEST_PATTERN_EN
                    o_sample <= i_pattern_en ? pat_cnt : shift_reg;
`else
                    o_sample <= shift_reg;
`endif
                end
                ST_DONE:  quiet_cnt <= QUIET_LOAD;
                ST_QUIET: if (quiet_cnt != '0) quiet_cnt <= quiet_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_sclk = sclk_q;
    assign o_cs_n = !in_frame;
    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);

endmodule

// File: tb/tb_spi_adc_reader.sv
// Directed bench for spi_adc_reader: default instance plus a CLK_DIV=1/QUIET_CYC=0 instance.
module tb_spi_adc_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, trig, miso, cs_n, sclk, busy, done;
    logic [11:0] sample;
    logic        trig2, miso2, cs2_n, sclk2, busy2, done2;
    logic [11:0] sample2;
`ifdef ADC_TEST_PATTERN_EN
    logic        pat_en;
    logic        pat2;
`endif

    int checks   = 0;
    int failures = 0;

    spi_adc_reader dut (
        .clk(clk), .rst(rst), .i_trigger(trig), .i_miso(miso),
`ifdef ADC_TEST_PATTERN_EN
        .i_pattern_en(pat_en),
`endif
        .o_cs_n(cs_n), .o_sclk(sclk), .o_busy(busy), .o_done(done), .o_sample(sample)
    );

    spi_adc_reader #(.CLK_DIV(1), .QUIET_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .i_trigger(trig2), .i_miso(miso2),
`ifdef ADC_TEST_PATTERN_EN
        .i_pattern_en(pat2),
`endif
        .o_cs_n(cs2_n), .o_sclk(sclk2), .o_busy(busy2), .o_done(done2), .o_sample(sample2)
    );

    // ADC models: new bit on falling SCLK, MSB first, restart on CS_n fall.
    logic [15:0] word = 16'h0;
    logic [15:0] word2 = 16'h0;
    int idx = 0;
    int idx2 = 0;
    always @(negedge cs_n) idx = 0;
    always @(negedge sclk) if (!cs_n && idx < 16) begin miso = word[15-idx]; idx++; end
    always @(negedge cs2_n) idx2 = 0;
    always @(negedge sclk2) if (!cs2_n && idx2 < 16) begin miso2 = word2[15-idx2]; idx2++; end

    int rises = 0;
    int done_cnt = 0;
    always @(posedge sclk) if (!cs_n) rises++;
    always @(negedge clk) if (done) done_cnt++;

    // Wait for idle, pulse trigger, return posedges from acceptance to o_done (-1 on timeout).
    task automatic run_frame(input logic [15:0] w, output int lat);
        int k;
        word = w;
        k = 0;
        while (busy && k < 50) begin @(negedge clk); k++; end
        trig = 1'b1;
        @(posedge clk);
        #1 trig = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin lat = n - 1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sample !== 12'h000) begin failures++; $display("FAIL reset_sample got=%h exp=000", sample); end
        checks++; if (cs2_n !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_dut2 cs_n=%b busy=%b exp=1,0", cs2_n, busy2); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int lat;
        rises = 0;
        run_frame(16'h0ABC, lat);
        checks++; if (lat !== 68) begin failures++; $display("FAIL single_latency got=%0d exp=68", lat); end
        checks++; if (sample !== 12'hABC) begin failures++; $display("FAIL single_sample got=%h exp=abc", sample); end
        checks++; if (rises !== 16) begin failures++; $display("FAIL single_sclk_count got=%0d exp=16", rises); end
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL single_cs_at_done got=%b exp=1", cs_n); end
        // DONE is followed by four QUIET cycles, then IDLE.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k <= 4) || done !== 1'b0 || cs_n !== 1'b1) begin
                failures++;
                $display("FAIL quiet_cycle%0d busy=%b done=%b cs_n=%b exp busy=%b done=0 cs_n=1", k, busy, done, cs_n, k <= 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t[3];
        int hi[3];
        int n;
        n = 0;
        hi = '{0, 0, 0};
        t = '{0, 0, 0};
        word2 = 16'h0123;
        @(negedge clk) trig2 = 1'b1;
        for (int c = 0; c < 300 && n < 3; c++) begin
            @(negedge clk);
            if (done2) begin
                t[n] = c;
                checks++; if (sample2 !== 12'h123) begin failures++; $display("FAIL b2b_sample%0d got=%h exp=123", n, sample2); end
                n++;
                if (n == 3) trig2 = 1'b0;
            end else if (n > 0 && cs2_n) begin
                hi[n]++;
            end
        end
        checks++; if (n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
        checks++; if (t[1] - t[0] !== 36) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=36", t[1] - t[0]); end
        checks++; if (t[2] - t[1] !== 36) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=36", t[2] - t[1]); end
        // CS_n high outside the DONE strobe: just the single IDLE cycle.
        checks++; if (hi[1] !== 1) begin failures++; $display("FAIL b2b_cs_high1 got=%0d exp=1", hi[1]); end
        checks++; if (hi[2] !== 1) begin failures++; $display("FAIL b2b_cs_high2 got=%0d exp=1", hi[2]); end
        @(negedge clk);
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy2); end
    endtask

    task automatic test_ignore();
        int d0;
        int k;
        word = 16'h0555;
        rises = 0;
        d0 = done_cnt;
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        repeat (20) @(negedge clk);
        trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        k = 0;
        while (!done && k < 100) begin @(negedge clk); k++; end
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        repeat (150) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (rises !== 16) begin failures++; $display("FAIL ignore_sclk_count got=%0d exp=16", rises); end
        checks++; if (sample !== 12'h555) begin failures++; $display("FAIL ignore_sample got=%h exp=555", sample); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int d0;
        int k;
        word = 16'hFFFF;
        rises = 0;
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        k = 0;
        while (rises < 7 && k < 200) begin @(negedge clk); k++; end
        checks++; if (rises !== 7 || cs_n !== 1'b0) begin failures++; $display("FAIL midrst_setup rises=%0d cs_n=%b exp 7,0", rises, cs_n); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0 || sample !== 12'h000 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs cs_n=%b sclk=%b busy=%b sample=%h done=%b exp 1,1,0,000,0", cs_n, sclk, busy, sample, done);
        end
        @(negedge clk) rst = 1'b0;
        d0 = done_cnt;
        repeat (100) @(negedge clk);
        checks++; if (done_cnt !== d0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_no_done dones=%0d busy=%b exp 0,0", done_cnt - d0, busy); end
    endtask

    task automatic test_all_ones();
        int lat;
        run_frame(16'hFFFF, lat);
        checks++; if (sample !== 12'hFFF) begin failures++; $display("FAIL ones_sample got=%h exp=fff", sample); end
        checks++; if (lat !== 68) begin failures++; $display("FAIL ones_latency got=%0d exp=68", lat); end
    endtask

`ifdef ADC_TEST_PATTERN_EN
    task automatic test_pattern();
        int lat;
        logic [11:0] exp_s;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        pat_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_frame(16'h0ABC, lat);
            exp_s = 12'(i);
            checks++; if (sample !== exp_s || lat !== 68) begin failures++; $display("FAIL pattern_frame%0d got=%h lat=%0d exp=%h lat=68", i, sample, lat, exp_s); end
        end
        pat_en = 1'b0;
        run_frame(16'h0ABC, lat);
        checks++; if (sample !== 12'hABC) begin failures++; $display("FAIL pattern_off got=%h exp=abc", sample); end
    endtask
`endif

    initial begin
        rst = 1'b1; trig = 1'b0; trig2 = 1'b0; miso = 1'b0; miso2 = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
        pat_en = 1'b0; pat2 = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_all_ones();
`ifdef ADC_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
